// File: rtl/life_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : life_run_controller
// Description : Sequencer for an 8x8 Game-of-Life datapath. Loads a seed
//               (fixed pattern or LFSR), paces generations with a tick
//               divider, supports pause and single-step, counts generations
//               and halts on extinction, still life or a generation limit.
// Ports       : clk, reset (async, active-high)
//               start/stop/step  - run control
//               use_lfsr, seed, lfsr_value - seed selection
//               grid             - current datapath grid (registered)
//               load_en/load_data, evolve_en - datapath strobes
//               gen_count, running, halted, halt_code - status
// Revision    : 1.0 - initial release
// ============================================================================
module life_run_controller #(
    parameter int GRID_W   = 64,
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              use_lfsr,
    input  logic [GRID_W-1:0] seed,
    input  logic [GRID_W-1:0] lfsr_value,
    input  logic [GRID_W-1:0] grid,
    output logic              load_en,
    output logic [GRID_W-1:0] load_data,
    output logic              evolve_en,
    output logic [GEN_W-1:0]  gen_count,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_code
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [GEN_W-1:0]    c_max_gen   = GEN_W'(MAX_GEN);
    localparam logic                c_limit_en  = (MAX_GEN != 0);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_check = 3'd3;
    localparam logic [2:0] c_st_pause = 3'd4;
    localparam logic [2:0] c_st_halt  = 3'd5;

    localparam logic [1:0] c_code_none  = 2'b00;
    localparam logic [1:0] c_code_empty = 2'b01;
    localparam logic [1:0] c_code_still = 2'b10;
    localparam logic [1:0] c_code_limit = 2'b11;

    logic [2:0]          r_state;
    logic [c_tick_w-1:0] r_tick;
    logic [GRID_W-1:0]   r_prev_grid;
    logic [GRID_W-1:0]   r_load_data;
    logic [GEN_W-1:0]    r_gen_count;
    logic [1:0]          r_halt_code;
    logic                r_from_pause;   // CHECK returns to PAUSE when set

    logic [2:0]          w_next_state;
    logic                w_load;
    logic                w_evolve;
    logic                w_tick_last;
    logic                w_grid_empty;
    logic                w_grid_still;
    logic                w_limit_hit;
    logic [GEN_W-1:0]    w_gen_inc;

    assign w_tick_last  = (r_tick == c_tick_last);
    assign w_grid_empty = (grid == '0);
    assign w_grid_still = (grid == r_prev_grid);
    assign w_limit_hit  = c_limit_en && (r_gen_count == c_max_gen);
    // Saturate at all-ones rather than wrapping back to zero.
    assign w_gen_inc    = (&r_gen_count) ? r_gen_count : r_gen_count + 1'b1;

    // Next-state and strobe decode
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_evolve     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_next_state = c_st_load;
            end
            c_st_load: begin
                w_load       = 1'b1;
                w_next_state = (r_load_data == '0) ? c_st_halt : c_st_run;
            end
            c_st_run: begin
                // stop wins over the tick: no evolve in the pausing cycle
                if (stop) begin
                    w_next_state = c_st_pause;
                end else if (w_tick_last) begin
                    w_evolve     = 1'b1;
                    w_next_state = c_st_check;
                end
            end
            c_st_check: begin
                if (w_grid_empty || w_grid_still || w_limit_hit)
                    w_next_state = c_st_halt;
                else
                    w_next_state = r_from_pause ? c_st_pause : c_st_run;
            end
            c_st_pause: begin
                if (start) begin
                    w_next_state = c_st_run;
                end else if (step) begin
                    w_evolve     = 1'b1;
                    w_next_state = c_st_check;
                end
            end
            c_st_halt: begin
                if (start) w_next_state = c_st_load;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_tick       <= '0;
            r_prev_grid  <= '0;
            r_load_data  <= '0;
            r_gen_count  <= '0;
            r_halt_code  <= c_code_none;
            r_from_pause <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_st_idle, c_st_halt: begin
                    if (start) r_load_data <= use_lfsr ? lfsr_value : seed;
                end
                c_st_load: begin
                    r_gen_count <= '0;
                    r_tick      <= '0;
                    r_halt_code <= (r_load_data == '0) ? c_code_empty : c_code_none;
                end
                c_st_run: begin
                    if (!stop) begin
                        if (w_tick_last) begin
                            r_tick       <= '0;
                            r_from_pause <= 1'b0;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                c_st_check: begin
                    if (w_grid_empty)      r_halt_code <= c_code_empty;
                    else if (w_grid_still) r_halt_code <= c_code_still;
                    else if (w_limit_hit)  r_halt_code <= c_code_limit;
                end
                c_st_pause: begin
                    if (!start && step) begin
                        r_tick       <= '0;
                        r_from_pause <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_evolve) begin
                r_prev_grid <= grid;
                r_gen_count <= w_gen_inc;
            end
        end
    end

    assign load_en   = w_load;
    assign evolve_en = w_evolve;
    assign load_data = r_load_data;
    assign gen_count = r_gen_count;
    assign halt_code = r_halt_code;
    assign halted    = (r_state == c_st_halt);
    assign running   = (r_state == c_st_run) ||
                       ((r_state == c_st_check) && !r_from_pause);

endmodule
`default_nettype wire

// File: tb/tb_life_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_run_controller
// Description : Self-checking bench for life_run_controller with a
//               behavioural 8x8 Game-of-Life datapath (dead borders).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_run_controller;

    localparam logic [63:0] c_block  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] c_lone   = 64'h0000_0008_0000_0000;
    localparam logic [63:0] c_blink  = 64'h0000_0038_0000_0000;
    localparam logic [63:0] c_blinkv = 64'h0000_1010_1000_0000;
    localparam logic [63:0] c_lfsr   = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, step, use_lfsr;
    logic [63:0] seed, lfsr_value, grid;
    logic        load_en, evolve_en, running, halted;
    logic [63:0] load_data;
    logic [15:0] gen_count;
    logic [1:0]  halt_code;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_overlap = 0;

    always #5 clk = ~clk;

    life_run_controller #(
        .GRID_W  (64),
        .TICK_DIV(4),
        .GEN_W   (16),
        .MAX_GEN (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .use_lfsr  (use_lfsr),
        .seed      (seed),
        .lfsr_value(lfsr_value),
        .grid      (grid),
        .load_en   (load_en),
        .load_data (load_data),
        .evolve_en (evolve_en),
        .gen_count (gen_count),
        .running   (running),
        .halted    (halted),
        .halt_code (halt_code)
    );

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8)
                            cnt += int'(g[63 - ((r + dr) * 8 + (c + dc))]);
                    end
                end
                n[63 - (r * 8 + c)] = (cnt == 3) || (cnt == 2 && g[63 - (r * 8 + c)]);
            end
        end
        return n;
    endfunction

    // Behavioural datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          grid <= '0;
        else if (load_en)   grid <= load_data;
        else if (evolve_en) grid <= life_next(grid);
    end

    typedef struct {
        logic        start, stop, step;
        logic [63:0] seed;
        logic        ld, ev, run, hlt;
        logic [1:0]  code;
        logic [15:0] gen;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic p, input logic t,
                                input logic [63:0] sd, input logic ld, input logic ev,
                                input logic run, input logic hlt, input logic [1:0] code,
                                input logic [15:0] gen);
        vec_t v;
        v.start = s;  v.stop = p;  v.step = t;  v.seed = sd;
        v.ld = ld;    v.ev = ev;   v.run = run; v.hlt = hlt;
        v.code = code; v.gen = gen;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, leave 1ns to settle.
    task automatic cyc(input logic s, input logic p, input logic t, input logic l,
                       input logic [63:0] sd);
        @(negedge clk);
        start = s; stop = p; step = t; use_lfsr = l; seed = sd;
        #1;
        if (load_en && evolve_en) n_overlap++;
    endtask

    vec_t vecs[21];
    int   ev_seen;
    int   run_seen;

    initial begin
        reset = 1'b1; start = 0; stop = 0; step = 0; use_lfsr = 0;
        seed = '0; lfsr_value = c_lfsr;

        // T1 empty seed, T2 block, T3 lone cell
        vecs[0]  = mk(1, 0, 0, 64'd0,   0, 0, 0, 0, 2'b00, 16'd0);
        vecs[1]  = mk(0, 0, 0, 64'd0,   1, 0, 0, 0, 2'b00, 16'd0);
        vecs[2]  = mk(0, 0, 0, 64'd0,   0, 0, 0, 1, 2'b01, 16'd0);
        vecs[3]  = mk(0, 0, 0, 64'd0,   0, 0, 0, 1, 2'b01, 16'd0);
        vecs[4]  = mk(1, 0, 0, c_block, 0, 0, 0, 1, 2'b01, 16'd0);
        vecs[5]  = mk(0, 0, 0, c_block, 1, 0, 0, 0, 2'b01, 16'd0);
        vecs[6]  = mk(0, 0, 0, c_block, 0, 0, 1, 0, 2'b00, 16'd0);
        vecs[7]  = mk(1, 0, 0, c_block, 0, 0, 1, 0, 2'b00, 16'd0);
        vecs[8]  = mk(0, 0, 0, c_block, 0, 0, 1, 0, 2'b00, 16'd0);
        vecs[9]  = mk(0, 0, 0, c_block, 0, 1, 1, 0, 2'b00, 16'd0);
        vecs[10] = mk(0, 1, 0, c_block, 0, 0, 1, 0, 2'b00, 16'd1);
        vecs[11] = mk(0, 0, 0, c_block, 0, 0, 0, 1, 2'b10, 16'd1);
        vecs[12] = mk(0, 0, 0, c_block, 0, 0, 0, 1, 2'b10, 16'd1);
        vecs[13] = mk(1, 0, 0, c_lone,  0, 0, 0, 1, 2'b10, 16'd1);
        vecs[14] = mk(0, 0, 0, c_lone,  1, 0, 0, 0, 2'b10, 16'd1);
        vecs[15] = mk(0, 0, 0, c_lone,  0, 0, 1, 0, 2'b00, 16'd0);
        vecs[16] = mk(0, 0, 0, c_lone,  0, 0, 1, 0, 2'b00, 16'd0);
        vecs[17] = mk(0, 0, 0, c_lone,  0, 0, 1, 0, 2'b00, 16'd0);
        vecs[18] = mk(0, 0, 0, c_lone,  0, 1, 1, 0, 2'b00, 16'd0);
        vecs[19] = mk(0, 0, 0, c_lone,  0, 0, 1, 0, 2'b00, 16'd1);
        vecs[20] = mk(0, 0, 0, c_lone,  0, 0, 0, 1, 2'b01, 16'd1);

        // Reset state
        @(negedge clk);
        #1;
        check("reset_outputs", {load_en, evolve_en, running, halted, halt_code, gen_count},
              64'd0);
        check("reset_load_data", load_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].start, vecs[i].stop, vecs[i].step, 1'b0, vecs[i].seed);
            check($sformatf("vec[%0d]", i),
                  {load_en, evolve_en, running, halted, halt_code, gen_count},
                  {vecs[i].ld, vecs[i].ev, vecs[i].run, vecs[i].hlt, vecs[i].code, vecs[i].gen});
        end
        check("t3_grid_empty", grid, 64'd0);

        // T4 blinker up to the generation limit of 5
        cyc(1, 0, 0, 0, c_blink);
        check("t4_halted_before", halted, 1'b1);
        cyc(0, 0, 0, 0, c_blink);
        check("t4_load_en", load_en, 1'b1);
        for (int k = 0; k < 25; k++) begin
            cyc(0, 0, 0, 0, c_blink);
            check($sformatf("t4_evolve[%0d]", k), evolve_en, (k % 5) == 3);
            if ((k % 5) == 4)
                check($sformatf("t4_gen[%0d]", k), gen_count, 64'(k / 5 + 1));
        end
        cyc(0, 0, 0, 0, c_blink);
        check("t4_halted", halted, 1'b1);
        check("t4_code", halt_code, 2'b11);
        check("t4_gen", gen_count, 16'd5);
        check("t4_grid_vertical", grid, c_blinkv);
        cyc(0, 0, 0, 0, c_blink);
        check("t4_no_evolve_in_halt", evolve_en, 1'b0);

        // T5 pause / step / resume
        cyc(1, 0, 0, 0, c_blink);
        cyc(0, 0, 0, 0, c_blink);
        check("t5_load_en", load_en, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0, c_blink);
            check($sformatf("t5_evolve[%0d]", k), evolve_en, k == 3);
        end
        cyc(0, 1, 0, 0, c_blink);              // RUN with tick at last count
        check("t5_stop_beats_tick", evolve_en, 1'b0);
        check("t5_running_at_stop", running, 1'b1);
        ev_seen = 0;
        run_seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 0, 0, c_blink);
            if (evolve_en) ev_seen++;
            if (running) run_seen++;
        end
        check("t5_pause_evolves", 64'(ev_seen), 64'd0);
        check("t5_pause_running", 64'(run_seen), 64'd0);
        check("t5_pause_gen", gen_count, 16'd1);
        cyc(1, 0, 0, 0, c_blink);              // resume
        check("t5_resume_cycle", evolve_en, 1'b0);
        cyc(0, 0, 0, 0, c_blink);              // held tick was last count
        check("t5_resume_evolve", evolve_en, 1'b1);
        cyc(0, 0, 0, 0, c_blink);
        check("t5_check_gen2", gen_count, 16'd2);
        check("t5_check_running", running, 1'b1);
        cyc(0, 1, 0, 0, c_blink);
        check("t5_stop2", evolve_en, 1'b0);
        cyc(0, 0, 1, 0, c_blink);
        check("t5_step_evolve", evolve_en, 1'b1);
        check("t5_step_running", running, 1'b0);
        cyc(1, 0, 0, 0, c_blink);              // CHECK ignores start
        check("t5_step_check_gen", gen_count, 16'd3);
        check("t5_step_check_running", running, 1'b0);
        check("t5_step_check_halted", halted, 1'b0);
        cyc(1, 0, 1, 0, c_blink);              // back in PAUSE; start beats step
        check("t5_start_beats_step", evolve_en, 1'b0);
        check("t5_paused_running", running, 1'b0);
        cyc(0, 0, 0, 0, c_blink);
        check("t5_resumed_running", running, 1'b1);
        check("t5_gen3", gen_count, 16'd3);

        // T6 asynchronous reset mid-run, then LFSR seed
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_outputs", {load_en, evolve_en, running, halted, halt_code, gen_count},
              64'd0);
        check("t6_async_load_data", load_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 1, c_blink);
        check("t6_idle", {load_en, running, halted}, 64'd0);
        cyc(0, 0, 0, 1, c_blink);
        check("t6_load_en", load_en, 1'b1);
        check("t6_load_data", load_data, c_lfsr);
        check("t6_gen0", gen_count, 16'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, c_blink);
            check($sformatf("t6_evolve[%0d]", k), evolve_en, k == 3);
        end
        check("t6_gen1", gen_count, 16'd1);

        check("strobe_overlap", 64'(n_overlap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
